// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// Sizes here are the defaults used by dmem_responder and its store buffer.
package dmem_pkg;

    localparam int DM_N        = 64;
    localparam int DM_DEPTH    = 64;
    localparam int DM_SB_DEPTH = 4;

    localparam int IDX_W = $clog2(DM_DEPTH);
    localparam int PTR_W = $clog2(DM_SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic [DM_N-1:0]  data;
    } sb_entry_t;

    function automatic logic [IDX_W-1:0] word_idx(input logic [DM_N-1:0] addr);
        return addr[IDX_W+2:3];
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// DM bus between the pipeline (master) and the data memory (slave).
// Loads are answered combinationally on DM_readData in the same cycle.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int N = DM_N
);

    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] DM_readData;
    logic         dm_stall;
    logic         dm_misaligned;

    modport master (
        output DM_addr,
        output DM_writeData,
        output DM_writeEnable,
        output DM_readEnable,
        input  DM_readData,
        input  dm_stall,
        input  dm_misaligned
    );

    modport slave (
        input  DM_addr,
        input  DM_writeData,
        input  DM_writeEnable,
        input  DM_readEnable,
        output DM_readData,
        output dm_stall,
        output dm_misaligned
    );

endinterface

// File: rtl/dmem_store_buffer.sv
// Circular store buffer with associative lookup, in-place coalescing
// and a head-pop port that feeds the array.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int SB_DEPTH = DM_SB_DEPTH,
    parameter int SB_PTR_W = $clog2(SB_DEPTH),
    parameter int SB_CNT_W = SB_PTR_W + 1
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    i_idx,
    input  logic [DM_N-1:0]     i_data,
    input  logic                i_push,
    input  logic                i_coal,
    input  logic                i_pop,
    output logic                o_hit,
    output logic [SB_PTR_W-1:0] o_hit_slot,
    output logic [DM_N-1:0]     o_hit_data,
    output logic                o_full,
    output logic                o_empty,
    output logic [IDX_W-1:0]    o_head_idx,
    output logic [DM_N-1:0]     o_head_data
);

    sb_entry_t             r_ent [SB_DEPTH];
    logic [SB_PTR_W-1:0]   r_head;
    logic [SB_PTR_W-1:0]   r_tail;
    logic [SB_CNT_W-1:0]   r_count;
    logic [SB_PTR_W-1:0]   w_slot;

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_slot = '0;
        o_hit_data = '0;
        w_slot     = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            w_slot = r_head + SB_PTR_W'(k);
            if (r_ent[w_slot].valid && r_ent[w_slot].idx == i_idx) begin
                o_hit      = 1'b1;
                o_hit_slot = w_slot;
                o_hit_data = r_ent[w_slot].data;
            end
        end
    end

    assign o_full     = (r_count == SB_CNT_W'(SB_DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_idx = r_ent[r_head].idx;

    // A store coalescing onto the draining head must reach the array.
    assign o_head_data = (i_coal && o_hit_slot == r_head) ?
                         i_data : r_ent[r_head].data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SB_DEPTH; k++) begin
                r_ent[k] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_coal) begin
                r_ent[o_hit_slot].data <= i_data;
            end
            if (i_pop) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + SB_PTR_W'(1);
            end
            // Placed after the pop so a full-and-draining push keeps its slot.
            if (i_push) begin
                r_ent[r_tail] <= '{valid: 1'b1, idx: i_idx, data: i_data};
                r_tail        <= r_tail + SB_PTR_W'(1);
            end
            r_count <= r_count + SB_CNT_W'(i_push) - SB_CNT_W'(i_pop);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array behind a store buffer, zero-latency loads.
// Optional macro DMEM_MISALIGN_CHECK_EN suppresses and flags misaligned accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N        = DM_N,
    parameter int DEPTH    = DM_DEPTH,
    parameter int SB_DEPTH = DM_SB_DEPTH
)(
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  dm
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = $clog2(SB_DEPTH);

    logic [N-1:0]   r_mem [DEPTH];
    logic [IW-1:0]  w_idx;
    logic           w_ok;
    logic           w_ld;
    logic           w_st;
    logic           w_drain;
    logic           w_hit;
    logic           w_coal;
    logic           w_push;
    logic           w_full;
    logic           w_empty;
    logic [SPW-1:0] w_hit_slot;
    logic [N-1:0]   w_hit_data;
    logic [IW-1:0]  w_head_idx;
    logic [N-1:0]   w_head_data;
    logic           w_unused;

    assign w_idx = dm.DM_addr[IW+2:3];

`ifdef DMEM_MISALIGN_CHECK_EN
    logic r_mis;

    assign w_ok = (dm.DM_addr[2:0] == 3'b000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mis <= 1'b0;
        end else if ((dm.DM_readEnable || dm.DM_writeEnable) && !w_ok) begin
            r_mis <= 1'b1;
        end
    end

    assign dm.dm_misaligned = r_mis;
`else
    assign w_ok             = 1'b1;
    assign dm.dm_misaligned = 1'b0;
`endif

    assign w_ld = dm.DM_readEnable  & w_ok;
    assign w_st = dm.DM_writeEnable & w_ok;

    // Any load, aligned or not, occupies the array port.
    assign w_drain = ~w_empty & ~dm.DM_readEnable;
    assign w_coal  = w_st & w_hit;
    assign w_push  = w_st & ~w_hit & (~w_full | w_drain);

    assign dm.dm_stall = w_st & w_full & ~w_drain & ~w_hit;

    assign dm.DM_readData = !w_ld ? '0 :
                            w_hit ? w_hit_data : r_mem[w_idx];

    dmem_store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .i_idx       (w_idx),
        .i_data      (dm.DM_writeData),
        .i_push      (w_push),
        .i_coal      (w_coal),
        .i_pop       (w_drain),
        .o_hit       (w_hit),
        .o_hit_slot  (w_hit_slot),
        .o_hit_data  (w_hit_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_idx  (w_head_idx),
        .o_head_data (w_head_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_drain) begin
            r_mem[w_head_idx] <= w_head_data;
        end
    end

    assign w_unused = ^{dm.DM_addr[N-1:IW+3], dm.DM_addr[2:0], w_hit_slot};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: queue-level reference model checked every
// cycle on the falling edge, plus directed literal checks and random traffic.
module tb_dmem_responder;

    typedef struct {
        int          idx;
        logic [63:0] data;
    } ent_t;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dmem_responder_if #(.N(64)) dm ();

    dmem_responder #(
        .N        (64),
        .DEPTH    (64),
        .SB_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .dm    (dm)
    );

    ent_t        m_q[$];
    logic [63:0] m_mem [64];
    bit          m_mis;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffer is an ordered queue, array a plain word table.
    logic [63:0] e_rd;
    bit          e_stall;
    bit          e_ok;
    bit          e_drain;
    int          e_idx;
    int          e_hit;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rdata", dm.DM_readData, 64'd0);
            chk("rst_stall", 64'(dm.dm_stall), 64'd0);
            chk("rst_mis", 64'(dm.dm_misaligned), 64'd0);
            m_q.delete();
            foreach (m_mem[i]) m_mem[i] = 64'd0;
            m_mis = 1'b0;
        end else begin
            e_idx = int'(dm.DM_addr[8:3]);
            e_ok  = MIS_EN ? (dm.DM_addr[2:0] == 3'd0) : 1'b1;
            e_hit = -1;
            for (int i = m_q.size() - 1; i >= 0; i--) begin
                if (e_hit < 0 && m_q[i].idx == e_idx) e_hit = i;
            end
            e_rd = 64'd0;
            if (dm.DM_readEnable && e_ok) begin
                e_rd = (e_hit >= 0) ? m_q[e_hit].data : m_mem[e_idx];
            end
            e_drain = (m_q.size() > 0) && !dm.DM_readEnable;
            e_stall = dm.DM_writeEnable && e_ok && e_hit < 0 &&
                      m_q.size() == 4 && !e_drain;

            chk("rdata", dm.DM_readData, e_rd);
            chk("stall", 64'(dm.dm_stall), 64'(e_stall));
            chk("mis", 64'(dm.dm_misaligned), 64'(m_mis));

            if ((dm.DM_readEnable || dm.DM_writeEnable) && !e_ok) m_mis = 1'b1;
            if (dm.DM_writeEnable && e_ok && e_hit >= 0) begin
                m_q[e_hit].data = dm.DM_writeData;
            end
            if (e_drain) begin
                m_mem[m_q[0].idx] = m_q[0].data;
                void'(m_q.pop_front());
            end
            if (dm.DM_writeEnable && e_ok && e_hit < 0 && !e_stall) begin
                m_q.push_back('{idx: e_idx, data: dm.DM_writeData});
            end
        end
    end

    task automatic drive(input bit we, input bit re,
                         input logic [63:0] a, input logic [63:0] d);
        @(posedge clk);
        #2;
        dm.DM_writeEnable = we;
        dm.DM_readEnable  = re;
        dm.DM_addr        = a;
        dm.DM_writeData   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    logic [63:0] r_a;

    initial begin
        dm.DM_writeEnable = 1'b0;
        dm.DM_readEnable  = 1'b1;
        dm.DM_addr        = 64'h58;
        dm.DM_writeData   = 64'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        drive(1'b0, 1'b1, 64'h58, 64'd0);
        #1 chk("post_rst_rd", dm.DM_readData, 64'd0);
        chk("post_rst_stall", 64'(dm.dm_stall), 64'd0);
        chk("post_rst_mis", 64'(dm.dm_misaligned), 64'd0);

        // Forwarding while loads keep the array port busy.
        drive(1'b1, 1'b1, 64'h10, 64'hDEAD_BEEF);
        #1 chk("same_cycle_no_bypass", dm.DM_readData, 64'd0);
        drive(1'b0, 1'b1, 64'h10, 64'd0);
        #1 chk("fwd_hit", dm.DM_readData, 64'hDEAD_BEEF);
        drive(1'b0, 1'b1, 64'h18, 64'd0);
        #1 chk("model_occ_1", 64'(m_q.size()), 64'd1);
        idle(4);
        drive(1'b0, 1'b1, 64'h10, 64'd0);
        #1 chk("array_rd", dm.DM_readData, 64'hDEAD_BEEF);
        chk("model_drained", 64'(m_q.size()), 64'd0);

        // Back-to-back stores to one word coalesce.
        drive(1'b1, 1'b1, 64'h20, 64'h1);
        drive(1'b1, 1'b1, 64'h20, 64'h2);
        drive(1'b0, 1'b1, 64'h28, 64'd0);
        #1 chk("model_coalesce_occ", 64'(m_q.size()), 64'd1);
        drive(1'b0, 1'b1, 64'h20, 64'd0);
        #1 chk("coalesced_rd", dm.DM_readData, 64'h2);
        idle(4);

        // Fill the buffer, then free a slot by dropping the load.
        drive(1'b1, 1'b1, 64'h00, 64'hA0);
        drive(1'b1, 1'b1, 64'h08, 64'hA1);
        drive(1'b1, 1'b1, 64'h10, 64'hA2);
        drive(1'b1, 1'b1, 64'h18, 64'hA3);
        drive(1'b1, 1'b1, 64'h20, 64'hA4);
        #1 chk("stall_5th", 64'(dm.dm_stall), 64'd1);
        drive(1'b1, 1'b0, 64'h20, 64'hA4);
        #1 chk("full_drain_accept", 64'(dm.dm_stall), 64'd0);
        idle(5);
        drive(1'b0, 1'b1, 64'h20, 64'd0);
        #1 chk("rd_5th", dm.DM_readData, 64'hA4);
        drive(1'b0, 1'b1, 64'h00, 64'd0);
        #1 chk("rd_1st", dm.DM_readData, 64'hA0);

        // Reset with entries still pending discards them.
        drive(1'b1, 1'b1, 64'h100, 64'h111);
        drive(1'b1, 1'b1, 64'h108, 64'h222);
        drive(1'b1, 1'b1, 64'h110, 64'h333);
        drive(1'b0, 1'b1, 64'h100, 64'd0);
        chk("model_pending_3", 64'(m_q.size()), 64'd3);
        rst_n = 1'b0;
        #1 chk("rst_mid_rd", dm.DM_readData, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        drive(1'b0, 1'b1, 64'h100, 64'd0);
        #1 chk("rst_lost_0", dm.DM_readData, 64'd0);
        drive(1'b0, 1'b1, 64'h108, 64'd0);
        #1 chk("rst_lost_1", dm.DM_readData, 64'd0);
        drive(1'b0, 1'b1, 64'h10, 64'd0);
        #1 chk("rst_array_clr", dm.DM_readData, 64'd0);

        // Misaligned store.
        drive(1'b1, 1'b0, 64'h08, 64'h77);
        idle(2);
        drive(1'b1, 1'b0, 64'h0C, 64'h55);
        idle(3);
        drive(1'b0, 1'b1, 64'h08, 64'd0);
        #1 chk("misalign_rd", dm.DM_readData, MIS_EN ? 64'h77 : 64'h55);
        chk("misalign_flag", 64'(dm.dm_misaligned), 64'(MIS_EN));
        idle(1);
        #1 chk("misalign_sticky", 64'(dm.dm_misaligned), 64'(MIS_EN));

        // Random traffic over a few words, upper address bits as noise.
        for (int i = 0; i < 800; i++) begin
            r_a       = {$urandom(), $urandom()};
            r_a[8:3]  = 6'($urandom_range(0, 5));
            r_a[2:0]  = ($urandom_range(0, 7) == 0) ? 3'($urandom()) : 3'd0;
            drive(1'($urandom()), ($urandom_range(0, 2) != 0), r_a,
                  {$urandom(), $urandom()});
            if (i == 400) begin
                rst_n = 1'b0;
                @(posedge clk);
                #2 rst_n = 1'b1;
            end
        end
        idle(6);
        drive(1'b0, 1'b1, 64'h08, 64'd0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
